// File: rtl/eth_idma_xfer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_idma_xfer_sched_pkg
// Brief   : Shared types for the Ethernet iDMA transfer scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package eth_idma_xfer_sched_pkg;

  typedef enum logic [0:0] {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } dir_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  typedef enum logic [2:0] {
    AXI        = 3'd0,
    OBI        = 3'd1,
    AXI_STREAM = 3'd2
  } protocol_e;

  // TX reads memory and writes the MAC stream; RX is the mirror image.
  function automatic protocol_e src_prot(input dir_e d);
    return (d == DIR_TX) ? AXI : AXI_STREAM;
  endfunction

  function automatic protocol_e dst_prot(input dir_e d);
    return (d == DIR_TX) ? AXI_STREAM : AXI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_idma_xfer_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module  : eth_idma_xfer_sched_fifo
// Brief   : Small synchronous FIFO holding direction tags of in-flight transfers.
// Revision: 1.0 - initial release
// ============================================================================
module eth_idma_xfer_sched_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [PTR_WIDTH-1:0] c_last  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_depth = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty_o   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!w_full || w_do_pop);
  assign data_o    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/eth_idma_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module  : eth_idma_xfer_sched
// Brief   : Round-robin TX/RX scheduler onto a single iDMA 1D request port.
// Revision: 1.0 - initial release
// ============================================================================
module eth_idma_xfer_sched
  import eth_idma_xfer_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned TFLEN_WIDTH     = 32,
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned TX_AXI_ID       = 0,
  parameter int unsigned RX_AXI_ID       = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [ADDR_WIDTH-1:0]   tx_addr_i,
  input  logic [TFLEN_WIDTH-1:0]  tx_len_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rx_addr_i,
  input  logic [TFLEN_WIDTH-1:0]  rx_len_i,
  output logic                    idma_valid_o,
  input  logic                    idma_ready_i,
  output logic [TFLEN_WIDTH-1:0]  idma_len_o,
  output logic [ADDR_WIDTH-1:0]   idma_src_addr_o,
  output logic [ADDR_WIDTH-1:0]   idma_dst_addr_o,
  output protocol_e               idma_src_prot_o,
  output protocol_e               idma_dst_prot_o,
  output logic [AXI_ID_WIDTH-1:0] idma_axi_id_o,
  input  logic                    idma_rsp_valid_i,
  output logic                    idma_rsp_ready_o,
  input  logic                    idma_rsp_error_i,
  output logic                    tx_done_o,
  output logic                    rx_done_o,
  output logic                    tx_err_o,
  output logic                    rx_err_o,
  output logic [CNT_WIDTH-1:0]    outstanding_o,
  output logic                    busy_o
);

  localparam logic [CNT_WIDTH-1:0] c_max = CNT_WIDTH'(MAX_OUTSTANDING);

  sched_state_e            r_state;
  logic                    r_rr_rx;
  dir_e                    r_dir;
  logic                    r_idma_valid;
  logic [TFLEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic [ADDR_WIDTH-1:0]   r_dst;
  protocol_e               r_src_prot;
  protocol_e               r_dst_prot;
  logic [AXI_ID_WIDTH-1:0] r_axi_id;
  logic [CNT_WIDTH-1:0]    r_outstanding;
  logic                    r_tx_done, r_rx_done, r_tx_err, r_rx_err;

  logic w_can_grant, w_pick_rx, w_push, w_pop, w_fifo_empty;
  logic [0:0] w_fifo_data;
  dir_e w_tag;

  // Grant gated by reset so no requester sees a handshake that reset discards.
  assign w_can_grant = !rst_i && (r_state == IDLE) && en_i && (r_outstanding < c_max)
                       && (tx_valid_i || rx_valid_i);
  assign w_pick_rx   = rx_valid_i && (!tx_valid_i || r_rr_rx);
  assign tx_ready_o  = w_can_grant && !w_pick_rx;
  assign rx_ready_o  = w_can_grant && w_pick_rx;

  assign w_push = r_idma_valid && idma_ready_i;
  assign w_pop  = idma_rsp_valid_i && !w_fifo_empty;
  assign w_tag  = dir_e'(w_fifo_data);

  assign idma_valid_o     = r_idma_valid;
  assign idma_len_o       = r_len;
  assign idma_src_addr_o  = r_src;
  assign idma_dst_addr_o  = r_dst;
  assign idma_src_prot_o  = r_src_prot;
  assign idma_dst_prot_o  = r_dst_prot;
  assign idma_axi_id_o    = r_axi_id;
  assign idma_rsp_ready_o = !w_fifo_empty;
  assign tx_done_o        = r_tx_done;
  assign rx_done_o        = r_rx_done;
  assign tx_err_o         = r_tx_err;
  assign rx_err_o         = r_rx_err;
  assign outstanding_o    = r_outstanding;
  assign busy_o           = r_idma_valid || (r_outstanding != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_rr_rx      <= 1'b0;
      r_dir        <= DIR_TX;
      r_idma_valid <= 1'b0;
      r_len        <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_src_prot   <= AXI;
      r_dst_prot   <= AXI;
      r_axi_id     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_grant) begin
            r_state      <= ISSUE;
            r_idma_valid <= 1'b1;
            r_rr_rx      <= !w_pick_rx;
            r_dir        <= w_pick_rx ? DIR_RX : DIR_TX;
            r_src_prot   <= src_prot(w_pick_rx ? DIR_RX : DIR_TX);
            r_dst_prot   <= dst_prot(w_pick_rx ? DIR_RX : DIR_TX);
            r_len        <= w_pick_rx ? rx_len_i : tx_len_i;
            r_src        <= w_pick_rx ? '0 : tx_addr_i;
            r_dst        <= w_pick_rx ? rx_addr_i : '0;
            r_axi_id     <= w_pick_rx ? AXI_ID_WIDTH'(RX_AXI_ID) : AXI_ID_WIDTH'(TX_AXI_ID);
          end
        end
        ISSUE: begin
          if (idma_ready_i) begin
            r_state      <= IDLE;
            r_idma_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
      r_tx_done     <= 1'b0;
      r_rx_done     <= 1'b0;
      r_tx_err      <= 1'b0;
      r_rx_err      <= 1'b0;
    end else begin
      if (w_push && !w_pop)      r_outstanding <= r_outstanding + 1'b1;
      else if (!w_push && w_pop) r_outstanding <= r_outstanding - 1'b1;
      r_tx_done <= w_pop && (w_tag == DIR_TX);
      r_rx_done <= w_pop && (w_tag == DIR_RX);
      r_tx_err  <= w_pop && (w_tag == DIR_TX) && idma_rsp_error_i;
      r_rx_err  <= w_pop && (w_tag == DIR_RX) && idma_rsp_error_i;
    end
  end

  eth_idma_xfer_sched_fifo #(
    .DATA_WIDTH (1),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (!rst_i),
    .flush_i (rst_i),
    .push_i  (w_push),
    .data_i  (r_dir),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .empty_o (w_fifo_empty)
  );

  a_rsp_without_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    idma_rsp_valid_i |-> !w_fifo_empty);
  a_zero_len_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    (tx_ready_o |-> tx_len_i != '0) and (rx_ready_o |-> rx_len_i != '0));
  a_tx_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (tx_valid_i && !tx_ready_o) |=> (!tx_valid_i || ($stable(tx_addr_i) && $stable(tx_len_i))));
  a_rx_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (rx_valid_i && !rx_ready_o) |=> (!rx_valid_i || ($stable(rx_addr_i) && $stable(rx_len_i))));

endmodule
`default_nettype wire

// File: tb/tb_eth_idma_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_idma_xfer_sched
// Brief   : Self-checking bench for eth_idma_xfer_sched with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_idma_xfer_sched;
  import eth_idma_xfer_sched_pkg::*;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst_i, en_i;
  logic tx_valid_i, tx_ready_o, rx_valid_i, rx_ready_o;
  logic [31:0] tx_addr_i, tx_len_i, rx_addr_i, rx_len_i;
  logic idma_valid_o, idma_ready_i;
  logic [31:0] idma_len_o, idma_src_addr_o, idma_dst_addr_o;
  protocol_e idma_src_prot_o, idma_dst_prot_o;
  logic [0:0] idma_axi_id_o;
  logic idma_rsp_valid_i, idma_rsp_ready_o, idma_rsp_error_i;
  logic tx_done_o, rx_done_o, tx_err_o, rx_err_o;
  logic [2:0] outstanding_o;
  logic busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_idma_xfer_sched u_dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_addr_i(tx_addr_i), .tx_len_i(tx_len_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_addr_i(rx_addr_i), .rx_len_i(rx_len_i),
    .idma_valid_o(idma_valid_o), .idma_ready_i(idma_ready_i), .idma_len_o(idma_len_o),
    .idma_src_addr_o(idma_src_addr_o), .idma_dst_addr_o(idma_dst_addr_o),
    .idma_src_prot_o(idma_src_prot_o), .idma_dst_prot_o(idma_dst_prot_o),
    .idma_axi_id_o(idma_axi_id_o), .idma_rsp_valid_i(idma_rsp_valid_i),
    .idma_rsp_ready_o(idma_rsp_ready_o), .idma_rsp_error_i(idma_rsp_error_i),
    .tx_done_o(tx_done_o), .rx_done_o(rx_done_o), .tx_err_o(tx_err_o), .rx_err_o(rx_err_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0;
    tx_valid_i = 1'b0; tx_addr_i = '0; tx_len_i = '0;
    rx_valid_i = 1'b0; rx_addr_i = '0; rx_len_i = '0;
    idma_ready_i = 1'b0; idma_rsp_valid_i = 1'b0; idma_rsp_error_i = 1'b0;
    tick();
    rst_i = 1'b0; en_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({tx_ready_o, rx_ready_o, idma_valid_o, idma_rsp_ready_o, tx_done_o, rx_done_o,
         tx_err_o, rx_err_o, busy_o} !== 9'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {tx_ready_o, rx_ready_o, idma_valid_o,
        idma_rsp_ready_o, tx_done_o, rx_done_o, tx_err_o, rx_err_o, busy_o});
    end
    checks++;
    if (outstanding_o !== 3'd0) begin
      failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o);
    end
    checks++;
    if ({idma_len_o, idma_src_addr_o, idma_dst_addr_o} !== 96'b0) begin
      failures++; $display("FAIL reset_fields got=%h exp=0", {idma_len_o, idma_src_addr_o, idma_dst_addr_o});
    end
  endtask

  task automatic test_single_tx();
    do_reset();
    tx_valid_i = 1'b1; tx_addr_i = 32'h1000; tx_len_i = 32'd64; idma_ready_i = 1'b1;
    #1;
    checks++;
    if ({tx_ready_o, rx_ready_o} !== 2'b10) begin
      failures++; $display("FAIL single_tx_grant got=%b exp=10", {tx_ready_o, rx_ready_o});
    end
    tick();
    tx_valid_i = 1'b0;
    #1;
    checks++;
    if (idma_valid_o !== 1'b1 || idma_src_addr_o !== 32'h1000 || idma_dst_addr_o !== 32'h0 ||
        idma_len_o !== 32'd64 || idma_src_prot_o !== AXI || idma_dst_prot_o !== AXI_STREAM ||
        idma_axi_id_o !== 1'b0) begin
      failures++; $display("FAIL single_tx_req got=v%b s%h d%h l%0d p%0d/%0d id%0d exp=v1 s1000 d0 l64 p0/2 id0",
        idma_valid_o, idma_src_addr_o, idma_dst_addr_o, idma_len_o, idma_src_prot_o, idma_dst_prot_o, idma_axi_id_o);
    end
    tick();
    #1;
    checks++;
    if ({idma_valid_o, outstanding_o, idma_rsp_ready_o, busy_o} !== {1'b0, 3'd1, 1'b1, 1'b1}) begin
      failures++; $display("FAIL single_tx_issued got=%b exp=0_001_1_1", {idma_valid_o, outstanding_o, idma_rsp_ready_o, busy_o});
    end
    idma_rsp_valid_i = 1'b1; idma_rsp_error_i = 1'b0;
    tick();
    idma_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if ({tx_done_o, tx_err_o, rx_done_o, outstanding_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL single_tx_done got=%b exp=100_000", {tx_done_o, tx_err_o, rx_done_o, outstanding_o});
    end
    tick();
    #1;
    checks++;
    if ({tx_done_o, busy_o} !== 2'b00) begin
      failures++; $display("FAIL single_tx_pulse got=%b exp=00", {tx_done_o, busy_o});
    end
  endtask

  task automatic test_back_to_back();
    dir_e grants[$];
    do_reset();
    tx_valid_i = 1'b1; tx_addr_i = 32'hA000; tx_len_i = 32'd100;
    rx_valid_i = 1'b1; rx_addr_i = 32'hB000; rx_len_i = 32'd200;
    idma_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (tx_ready_o) grants.push_back(DIR_TX);
      if (rx_ready_o) grants.push_back(DIR_RX);
      tick();
    end
    tx_valid_i = 1'b0; rx_valid_i = 1'b0;
    #1;
    checks++;
    if (grants.size() != 4 || outstanding_o !== 3'd4) begin
      failures++; $display("FAIL b2b_count got=%0d/%0d exp=4/4", grants.size(), outstanding_o);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < grants.size()) begin
        checks++;
        if (grants[k] !== ((k % 2 == 0) ? DIR_TX : DIR_RX)) begin
          failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", k, grants[k], k % 2);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      idma_rsp_valid_i = 1'b1;
      tick();
      idma_rsp_valid_i = 1'b0;
      #1;
      checks++;
      if ({tx_done_o, rx_done_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL b2b_rsp[%0d] got=%b exp=%b", k, {tx_done_o, rx_done_o}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_max_outstanding();
    int n;
    n = 0;
    do_reset();
    tx_valid_i = 1'b1; tx_addr_i = 32'h3000; tx_len_i = 32'd128; idma_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (tx_ready_o) n++;
      tick();
    end
    #1;
    checks++;
    if (n != 4 || outstanding_o !== 3'd4 || tx_ready_o !== 1'b0) begin
      failures++; $display("FAIL max_out got=%0d/%0d/%b exp=4/4/0", n, outstanding_o, tx_ready_o);
    end
    idma_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if (tx_ready_o !== 1'b0) begin
      failures++; $display("FAIL max_out_same_cycle got=%b exp=0", tx_ready_o);
    end
    tick();
    idma_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 3'd3 || tx_ready_o !== 1'b1) begin
      failures++; $display("FAIL max_out_regrant got=%0d/%b exp=3/1", outstanding_o, tx_ready_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, l;
    a = $urandom; l = $urandom_range(1, 9000);
    do_reset();
    tx_valid_i = 1'b1; tx_addr_i = a; tx_len_i = l; idma_ready_i = 1'b0;
    #1;
    checks++;
    if (tx_ready_o !== 1'b1) begin
      failures++; $display("FAIL stall_grant got=%b exp=1", tx_ready_o);
    end
    tick();
    tx_addr_i = ~a; tx_len_i = l + 1; en_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (idma_valid_o !== 1'b1 || idma_src_addr_o !== a || idma_len_o !== l || tx_ready_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got=v%b s%h l%0d r%b exp=v1 s%h l%0d r0",
          i, idma_valid_o, idma_src_addr_o, idma_len_o, tx_ready_o, a, l);
      end
      tick();
    end
    en_i = 1'b1; idma_ready_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    #1;
    checks++;
    if (idma_valid_o !== 1'b0 || outstanding_o !== 3'd1) begin
      failures++; $display("FAIL stall_release got=%b/%0d exp=0/1", idma_valid_o, outstanding_o);
    end
  endtask

  task automatic test_rx_error();
    do_reset();
    rx_valid_i = 1'b1; rx_addr_i = 32'h2000; rx_len_i = 32'd256; idma_ready_i = 1'b1;
    #1;
    checks++;
    if ({tx_ready_o, rx_ready_o} !== 2'b01) begin
      failures++; $display("FAIL rx_grant got=%b exp=01", {tx_ready_o, rx_ready_o});
    end
    tick();
    rx_valid_i = 1'b0;
    #1;
    checks++;
    if (idma_src_addr_o !== 32'h0 || idma_dst_addr_o !== 32'h2000 || idma_len_o !== 32'd256 ||
        idma_src_prot_o !== AXI_STREAM || idma_dst_prot_o !== AXI || idma_axi_id_o !== 1'b1) begin
      failures++; $display("FAIL rx_req got=s%h d%h l%0d p%0d/%0d id%0d exp=s0 d2000 l256 p2/0 id1",
        idma_src_addr_o, idma_dst_addr_o, idma_len_o, idma_src_prot_o, idma_dst_prot_o, idma_axi_id_o);
    end
    tick();
    idma_rsp_valid_i = 1'b1; idma_rsp_error_i = 1'b1;
    tick();
    idma_rsp_valid_i = 1'b0; idma_rsp_error_i = 1'b0;
    #1;
    checks++;
    if ({rx_done_o, rx_err_o, tx_done_o, tx_err_o} !== 4'b1100) begin
      failures++; $display("FAIL rx_err got=%b exp=1100", {rx_done_o, rx_err_o, tx_done_o, tx_err_o});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_valid_i = 1'b1; tx_addr_i = 32'h4000; tx_len_i = 32'd32; idma_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tx_valid_i = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 3'd3) begin
      failures++; $display("FAIL mid_pre got=%0d exp=3", outstanding_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({outstanding_o, busy_o, idma_rsp_ready_o} !== 5'b0) begin
      failures++; $display("FAIL mid_reset got=%b exp=0", {outstanding_o, busy_o, idma_rsp_ready_o});
    end
  endtask

  // Model: a held request, a FIFO of issued directions and a "preferred side" bit.
  task automatic test_random();
    dir_e q[$];
    dir_e d, m_dir;
    logic m_hold, m_pref_rx, g, g_rx, tx_taken, rx_taken;
    logic [31:0] m_src, m_dst, m_len;
    logic [3:0] m_done;
    do_reset();
    m_hold = 0; m_pref_rx = 0; m_done = '0; tx_taken = 1; rx_taken = 1;
    m_src = '0; m_dst = '0; m_len = '0; m_dir = DIR_TX;
    for (int c = 0; c < 600; c++) begin
      en_i = ($urandom_range(0, 9) != 0);
      if (!tx_valid_i || tx_taken) begin
        tx_valid_i = $urandom_range(0, 1); tx_addr_i = $urandom; tx_len_i = $urandom_range(1, 4096);
      end
      if (!rx_valid_i || rx_taken) begin
        rx_valid_i = $urandom_range(0, 1); rx_addr_i = $urandom; rx_len_i = $urandom_range(1, 4096);
      end
      idma_ready_i = ($urandom_range(0, 2) != 0);
      idma_rsp_valid_i = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      idma_rsp_error_i = $urandom_range(0, 1);
      #1;
      g    = !m_hold && en_i && (q.size() < MAX) && (tx_valid_i || rx_valid_i);
      g_rx = rx_valid_i && (!tx_valid_i || m_pref_rx);
      checks++;
      if ({tx_ready_o, rx_ready_o} !== {g && !g_rx, g && g_rx}) begin
        failures++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, {tx_ready_o, rx_ready_o}, {g && !g_rx, g && g_rx});
      end
      checks++;
      if (idma_valid_o !== m_hold) begin
        failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, idma_valid_o, m_hold);
      end
      if (m_hold) begin
        checks++;
        if (idma_src_addr_o !== m_src || idma_dst_addr_o !== m_dst || idma_len_o !== m_len ||
            idma_axi_id_o !== ((m_dir == DIR_RX) ? 1'b1 : 1'b0) ||
            idma_src_prot_o !== ((m_dir == DIR_TX) ? AXI : AXI_STREAM) ||
            idma_dst_prot_o !== ((m_dir == DIR_TX) ? AXI_STREAM : AXI)) begin
          failures++; $display("FAIL rnd_fields c=%0d got=s%h d%h l%0d id%0d exp=s%h d%h l%0d dir%0d",
            c, idma_src_addr_o, idma_dst_addr_o, idma_len_o, idma_axi_id_o, m_src, m_dst, m_len, m_dir);
        end
      end
      checks++;
      if (outstanding_o !== 3'(q.size()) || idma_rsp_ready_o !== (q.size() != 0) ||
          busy_o !== (m_hold || q.size() != 0)) begin
        failures++; $display("FAIL rnd_count c=%0d got=%0d/%b/%b exp=%0d", c, outstanding_o, idma_rsp_ready_o, busy_o, q.size());
      end
      checks++;
      if ({tx_done_o, rx_done_o, tx_err_o, rx_err_o} !== m_done) begin
        failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, {tx_done_o, rx_done_o, tx_err_o, rx_err_o}, m_done);
      end
      m_done = '0;
      if (idma_rsp_valid_i) begin
        d = q.pop_front();
        m_done = (d == DIR_TX) ? {1'b1, 1'b0, idma_rsp_error_i, 1'b0} : {1'b0, 1'b1, 1'b0, idma_rsp_error_i};
      end
      if (m_hold && idma_ready_i) begin
        q.push_back(m_dir);
        m_hold = 0;
      end else if (g) begin
        m_hold = 1; m_pref_rx = !g_rx;
        m_dir = g_rx ? DIR_RX : DIR_TX;
        m_src = g_rx ? 32'h0 : tx_addr_i;
        m_dst = g_rx ? rx_addr_i : 32'h0;
        m_len = g_rx ? rx_len_i : tx_len_i;
      end
      tx_taken = g && !g_rx;
      rx_taken = g && g_rx;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_max_outstanding();
    test_stall();
    test_rx_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
